id_ex_ctrl_pipe: RTL and testbench

//  Decode stage control of the 5-stage pipeline. Decodes the IF/ID instruction into the

---
 rtl/id_ex_ctrl_pipe.sv | 232 +++++++++++++++++++++++
 tb/tb_id_ex_ctrl_pipe.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_ctrl_pipe.sv
// Decode-stage control for a 5-stage pipeline: instruction decode into the
// control bundle, load-use hazard detection and the ID/EX control register
// with flush/hold handling and a saturating hazard-bubble counter.
module id_ex_ctrl_pipe #(
  parameter int ALU_OP_W  = 4,
  parameter int EXT_ISA   = 1,
  parameter int HAZARD_EN = 1,
  parameter int CNT_W     = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                id_valid,
  input  logic [31:0]         id_instr,
  input  logic                flush,
  input  logic                hold,
  output logic                stall,
  output logic                ex_valid,
  output logic                ex_reg_write,
  output logic                ex_alu_src,
  output logic                ex_mem_read,
  output logic                ex_mem_write,
  output logic                ex_mem_to_reg,
  output logic                ex_branch,
  output logic                ex_branch_ne,
  output logic                ex_jump,
  output logic                ex_imm_zext,
  output logic                ex_illegal,
  output logic [ALU_OP_W-1:0] ex_alu_op,
  output logic [4:0]          ex_rs,
  output logic [4:0]          ex_rt,
  output logic [4:0]          ex_rd_dst,
  output logic [CNT_W-1:0]    stall_cnt
);

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_BNE   = 6'd5;
  localparam logic [5:0] OP_ADDI  = 6'd8;
  localparam logic [5:0] OP_SLTI  = 6'd10;
  localparam logic [5:0] OP_ANDI  = 6'd12;
  localparam logic [5:0] OP_ORI   = 6'd13;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_SLT = 3'd4;
  localparam logic [2:0] ALU_XOR = 3'd5;
  localparam logic [2:0] ALU_NOR = 3'd6;

  localparam int BW = 11 + ALU_OP_W + 15;

  logic [5:0] op;
  logic [5:0] funct;
  logic [4:0] rs;
  logic [4:0] rt;
  logic [4:0] rd;
  logic       unused_shamt;

  assign op    = id_instr[31:26];
  assign rs    = id_instr[25:21];
  assign rt    = id_instr[20:16];
  assign rd    = id_instr[15:11];
  assign funct = id_instr[5:0];
  assign unused_shamt = ^id_instr[10:6];

  logic       d_reg_write;
  logic       d_alu_src;
  logic       d_mem_read;
  logic       d_mem_write;
  logic       d_mem_to_reg;
  logic       d_branch;
  logic       d_branch_ne;
  logic       d_jump;
  logic       d_imm_zext;
  logic       d_illegal;
  logic [2:0] d_alu;
  logic [4:0] d_dst;

  // Decode the ID instruction into the raw control set.
  always_comb begin
    d_reg_write  = 1'b0;
    d_alu_src    = 1'b0;
    d_mem_read   = 1'b0;
    d_mem_write  = 1'b0;
    d_mem_to_reg = 1'b0;
    d_branch     = 1'b0;
    d_branch_ne  = 1'b0;
    d_jump       = 1'b0;
    d_imm_zext   = 1'b0;
    d_illegal    = 1'b0;
    d_alu        = ALU_ADD;
    d_dst        = '0;
    case (op)
      OP_RTYPE: begin
        d_reg_write = 1'b1;
        d_dst       = rd;
        case (funct)
          6'h20: d_alu = ALU_ADD;
          6'h22: d_alu = ALU_SUB;
          6'h24: d_alu = ALU_AND;
          6'h25: d_alu = ALU_OR;
          6'h2A: d_alu = ALU_SLT;
          6'h26: d_alu = ALU_XOR;
          6'h27: begin
            if (EXT_ISA != 0) d_alu = ALU_NOR;
            else              d_illegal = 1'b1;
          end
          default: d_illegal = 1'b1;
        endcase
      end
      OP_LW: begin
        d_alu_src    = 1'b1;
        d_mem_read   = 1'b1;
        d_mem_to_reg = 1'b1;
        d_reg_write  = 1'b1;
        d_dst        = rt;
      end
      OP_SW: begin
        d_alu_src   = 1'b1;
        d_mem_write = 1'b1;
      end
      OP_BEQ: begin
        d_branch = 1'b1;
        d_alu    = ALU_SUB;
      end
      OP_ADDI: begin
        d_alu_src   = 1'b1;
        d_reg_write = 1'b1;
        d_dst       = rt;
      end
      OP_BNE: begin
        if (EXT_ISA != 0) begin
          d_branch    = 1'b1;
          d_branch_ne = 1'b1;
          d_alu       = ALU_SUB;
        end else begin
          d_illegal = 1'b1;
        end
      end
      OP_J: begin
        if (EXT_ISA != 0) d_jump = 1'b1;
        else              d_illegal = 1'b1;
      end
      OP_ANDI, OP_ORI: begin
        if (EXT_ISA != 0) begin
          d_alu       = (op == OP_ANDI) ? ALU_AND : ALU_OR;
          d_imm_zext  = 1'b1;
          d_alu_src   = 1'b1;
          d_reg_write = 1'b1;
          d_dst       = rt;
        end else begin
          d_illegal = 1'b1;
        end
      end
      OP_SLTI: begin
        if (EXT_ISA != 0) begin
          d_alu       = ALU_SLT;
          d_alu_src   = 1'b1;
          d_reg_write = 1'b1;
          d_dst       = rt;
        end else begin
          d_illegal = 1'b1;
        end
      end
      default: d_illegal = 1'b1;
    endcase
    // An illegal instruction carries no side effects: drop every control
    // that the partial decode above may already have raised.
    if (d_illegal) begin
      d_reg_write  = 1'b0;
      d_alu_src    = 1'b0;
      d_mem_read   = 1'b0;
      d_mem_write  = 1'b0;
      d_mem_to_reg = 1'b0;
      d_branch     = 1'b0;
      d_branch_ne  = 1'b0;
      d_jump       = 1'b0;
      d_imm_zext   = 1'b0;
      d_alu        = ALU_ADD;
      d_dst        = '0;
    end
  end

  logic [BW-1:0] dec_b;
  logic [BW-1:0] ex_b;

  // Pack the decode into the ID/EX bundle; an empty ID slot decodes to a bubble.
  always_comb begin
    dec_b = '0;
    if (id_valid) begin
      dec_b = {1'b1, d_reg_write, d_alu_src, d_mem_read, d_mem_write,
               d_mem_to_reg, d_branch, d_branch_ne, d_jump, d_imm_zext,
               d_illegal, ALU_OP_W'(d_alu), rs, rt, d_dst};
    end
  end

  assign {ex_valid, ex_reg_write, ex_alu_src, ex_mem_read, ex_mem_write,
          ex_mem_to_reg, ex_branch, ex_branch_ne, ex_jump, ex_imm_zext,
          ex_illegal, ex_alu_op, ex_rs, ex_rt, ex_rd_dst} = ex_b;

  logic uses_rt;
  logic haz;

  assign uses_rt = (op == OP_RTYPE) || (op == OP_SW) || (op == OP_BEQ) ||
                   ((EXT_ISA != 0) && (op == OP_BNE));
  assign haz = (HAZARD_EN != 0) && id_valid && ex_valid && ex_mem_read &&
               (ex_rd_dst != 5'd0) &&
               ((ex_rd_dst == rs) || (uses_rt && (ex_rd_dst == rt)));
  assign stall = haz;

  // ID/EX register: flush beats hold, hold beats the load-use bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_b      <= '0;
      stall_cnt <= '0;
    end else if (flush) begin
      ex_b <= '0;
    end else if (!hold) begin
      if (haz) begin
        ex_b <= '0;
        if (stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
      end else begin
        ex_b <= dec_b;
      end
    end
  end

endmodule

// File: tb/tb_id_ex_ctrl_pipe.sv
// Bench for id_ex_ctrl_pipe: three instances (default, EXT_ISA=0, CNT_W=2)
// share stimulus and are compared against a behavioural pipeline model.
module tb_id_ex_ctrl_pipe;

  typedef struct packed {
    logic       valid, reg_write, alu_src, mem_read, mem_write, mem_to_reg;
    logic       branch, branch_ne, jump, imm_zext, illegal;
    logic [3:0] alu_op;
    logic [4:0] rs, rt, rd;
  } ctrl_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid;
  logic [31:0] id_instr;
  logic        flush;
  logic        hold;

  always #5 clk = ~clk;

  logic m_stall, m_v, m_rw, m_as, m_mr, m_mw, m_mtr, m_br, m_bne, m_j, m_z, m_ill;
  logic [3:0] m_alu;
  logic [4:0] m_rs, m_rt, m_rd;
  logic [15:0] m_cnt;
  logic e_stall, e_v, e_rw, e_as, e_mr, e_mw, e_mtr, e_br, e_bne, e_j, e_z, e_ill;
  logic [3:0] e_alu;
  logic [4:0] e_rs, e_rt, e_rd;
  logic [15:0] e_cnt;
  logic c_stall, c_v, c_rw, c_as, c_mr, c_mw, c_mtr, c_br, c_bne, c_j, c_z, c_ill;
  logic [3:0] c_alu;
  logic [4:0] c_rs, c_rt, c_rd;
  logic [1:0] c_cnt;

  id_ex_ctrl_pipe #(.ALU_OP_W(4), .EXT_ISA(1), .HAZARD_EN(1), .CNT_W(16)) dut_m (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_instr(id_instr),
    .flush(flush), .hold(hold), .stall(m_stall), .ex_valid(m_v),
    .ex_reg_write(m_rw), .ex_alu_src(m_as), .ex_mem_read(m_mr),
    .ex_mem_write(m_mw), .ex_mem_to_reg(m_mtr), .ex_branch(m_br),
    .ex_branch_ne(m_bne), .ex_jump(m_j), .ex_imm_zext(m_z),
    .ex_illegal(m_ill), .ex_alu_op(m_alu), .ex_rs(m_rs), .ex_rt(m_rt),
    .ex_rd_dst(m_rd), .stall_cnt(m_cnt));

  id_ex_ctrl_pipe #(.ALU_OP_W(4), .EXT_ISA(0), .HAZARD_EN(1), .CNT_W(16)) dut_e (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_instr(id_instr),
    .flush(flush), .hold(hold), .stall(e_stall), .ex_valid(e_v),
    .ex_reg_write(e_rw), .ex_alu_src(e_as), .ex_mem_read(e_mr),
    .ex_mem_write(e_mw), .ex_mem_to_reg(e_mtr), .ex_branch(e_br),
    .ex_branch_ne(e_bne), .ex_jump(e_j), .ex_imm_zext(e_z),
    .ex_illegal(e_ill), .ex_alu_op(e_alu), .ex_rs(e_rs), .ex_rt(e_rt),
    .ex_rd_dst(e_rd), .stall_cnt(e_cnt));

  id_ex_ctrl_pipe #(.ALU_OP_W(4), .EXT_ISA(1), .HAZARD_EN(1), .CNT_W(2)) dut_c (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_instr(id_instr),
    .flush(flush), .hold(hold), .stall(c_stall), .ex_valid(c_v),
    .ex_reg_write(c_rw), .ex_alu_src(c_as), .ex_mem_read(c_mr),
    .ex_mem_write(c_mw), .ex_mem_to_reg(c_mtr), .ex_branch(c_br),
    .ex_branch_ne(c_bne), .ex_jump(c_j), .ex_imm_zext(c_z),
    .ex_illegal(c_ill), .ex_alu_op(c_alu), .ex_rs(c_rs), .ex_rt(c_rt),
    .ex_rd_dst(c_rd), .stall_cnt(c_cnt));

  ctrl_t obs_m, obs_e, obs_c;
  assign obs_m = {m_v, m_rw, m_as, m_mr, m_mw, m_mtr, m_br, m_bne, m_j, m_z, m_ill, m_alu, m_rs, m_rt, m_rd};
  assign obs_e = {e_v, e_rw, e_as, e_mr, e_mw, e_mtr, e_br, e_bne, e_j, e_z, e_ill, e_alu, e_rs, e_rt, e_rd};
  assign obs_c = {c_v, c_rw, c_as, c_mr, c_mw, c_mtr, c_br, c_bne, c_j, c_z, c_ill, c_alu, c_rs, c_rt, c_rd};

  int n_tests = 0;
  int n_fail  = 0;

  // Model state: index 0 = extended ISA, index 1 = base ISA.
  ctrl_t ms[2];
  int    mcnt[2];
  int    mcnt2;
  logic  stall_seen;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'd0, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt);
    return {op, rs, rt, 16'h1234};
  endfunction

  // Reference decode, from the instruction-set description.
  function automatic ctrl_t dec(input logic [31:0] ins, input bit ext);
    ctrl_t c;
    logic [5:0] op;
    logic [5:0] fn;
    logic [5:0] rfn [7];
    bit ill;
    c = '0;
    op = ins[31:26];
    fn = ins[5:0];
    rfn = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h26, 6'h27};
    ill = 1'b0;
    c.valid = 1'b1;
    c.rs = ins[25:21];
    c.rt = ins[20:16];
    case (op)
      6'd0: begin
        ill = 1'b1;
        for (int i = 0; i < 7; i++)
          if (fn == rfn[i] && (i < 6 || ext)) begin
            ill = 1'b0;
            c.alu_op = 4'(i);
          end
        c.reg_write = 1'b1;
        c.rd = ins[15:11];
      end
      6'd35: begin c.alu_src = 1; c.mem_read = 1; c.mem_to_reg = 1; c.reg_write = 1; c.rd = ins[20:16]; end
      6'd43: begin c.alu_src = 1; c.mem_write = 1; end
      6'd4:  begin c.branch = 1; c.alu_op = 4'd1; end
      6'd8:  begin c.alu_src = 1; c.reg_write = 1; c.rd = ins[20:16]; end
      6'd5:  begin c.branch = 1; c.branch_ne = 1; c.alu_op = 4'd1; ill = !ext; end
      6'd2:  begin c.jump = 1; ill = !ext; end
      6'd12: begin c.alu_op = 4'd2; c.imm_zext = 1; c.alu_src = 1; c.reg_write = 1; c.rd = ins[20:16]; ill = !ext; end
      6'd13: begin c.alu_op = 4'd3; c.imm_zext = 1; c.alu_src = 1; c.reg_write = 1; c.rd = ins[20:16]; ill = !ext; end
      6'd10: begin c.alu_op = 4'd4; c.alu_src = 1; c.reg_write = 1; c.rd = ins[20:16]; ill = !ext; end
      default: ill = 1'b1;
    endcase
    if (ill) begin
      c = '0;
      c.valid = 1'b1;
      c.illegal = 1'b1;
      c.rs = ins[25:21];
      c.rt = ins[20:16];
    end
    return c;
  endfunction

  function automatic bit haz_of(input ctrl_t e, input bit ext, input logic v, input logic [31:0] ins);
    logic [5:0] op;
    bit ur;
    op = ins[31:26];
    ur = (op == 6'd0) || (op == 6'd43) || (op == 6'd4) || (ext && op == 6'd5);
    return v && e.valid && e.mem_read && (e.rd != 5'd0) &&
           ((e.rd == ins[25:21]) || (ur && e.rd == ins[20:16]));
  endfunction

  task automatic model_reset();
    ms[0] = '0; ms[1] = '0; mcnt[0] = 0; mcnt[1] = 0; mcnt2 = 0;
  endtask

  // One clock cycle: apply inputs, check stall, advance model, check registers.
  task automatic step(input logic v, input logic [31:0] ins, input logic f, input logic h);
    bit hz[2];
    @(negedge clk);
    id_valid = v; id_instr = ins; flush = f; hold = h;
    #1;
    for (int k = 0; k < 2; k++) hz[k] = haz_of(ms[k], k == 0, v, ins);
    stall_seen = m_stall;
    check("stall_m", {63'd0, m_stall}, {63'd0, hz[0]});
    check("stall_e", {63'd0, e_stall}, {63'd0, hz[1]});
    check("stall_c", {63'd0, c_stall}, {63'd0, hz[0]});
    for (int k = 0; k < 2; k++) begin
      if (f) ms[k] = '0;
      else if (!h) begin
        if (hz[k]) begin
          ms[k] = '0;
          mcnt[k] = (mcnt[k] + 1) & 16'hFFFF;
          if (k == 0 && mcnt2 < 3) mcnt2++;
        end else ms[k] = v ? dec(ins, k == 0) : '0;
      end
    end
    @(posedge clk);
    #1;
    check("ctrl_m", 64'(obs_m), 64'(ms[0]));
    check("ctrl_e", 64'(obs_e), 64'(ms[1]));
    check("ctrl_c", 64'(obs_c), 64'(ms[0]));
    check("cnt_m", 64'(m_cnt), 64'(mcnt[0]));
    check("cnt_e", 64'(e_cnt), 64'(mcnt[1]));
    check("cnt_c", 64'(c_cnt), 64'(mcnt2));
  endtask

  // Asynchronous reset away from the clock edge; outputs must clear at once.
  task automatic async_reset();
    id_valid = 0; flush = 0; hold = 0;
    #2;
    rst_n = 0;
    #1;
    model_reset();
    check("rst_ctrl_m", 64'(obs_m), 64'd0);
    check("rst_ctrl_e", 64'(obs_e), 64'd0);
    check("rst_cnt_m", 64'(m_cnt), 64'd0);
    check("rst_cnt_c", 64'(c_cnt), 64'd0);
    check("rst_stall", {63'd0, m_stall}, 64'd0);
    @(negedge clk);
    rst_n = 1;
  endtask

  logic [5:0] op_pool [10];
  logic [5:0] fn_pool [8];
  int exp6 [5];

  initial begin
    op_pool = '{6'd0, 6'd35, 6'd43, 6'd4, 6'd8, 6'd5, 6'd2, 6'd12, 6'd13, 6'd10};
    fn_pool = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h26, 6'h27, 6'h3F};
    exp6 = '{1, 2, 3, 3, 3};
    rst_n = 0; id_valid = 0; id_instr = '0; flush = 0; hold = 0;
    model_reset();
    #12;
    check("init_ctrl_m", 64'(obs_m), 64'd0);
    check("init_cnt_m", 64'(m_cnt), 64'd0);
    @(negedge clk);
    rst_n = 1;

    // Extended decode versus base decode.
    step(1, itype(6'd13, 5'd3, 5'd7), 0, 0);
    check("ori_alu", 64'(m_alu), 64'd3);
    check("ori_src_zext", {62'd0, m_as, m_z}, 64'd3);
    check("ori_dst", 64'(m_rd), 64'd7);
    check("ori_base_ill", {61'd0, e_ill, e_v, e_rw}, 64'b110);
    step(1, rtype(5'd1, 5'd2, 5'd3, 6'h3F), 0, 0);
    check("rfn3f_ill", {63'd0, m_ill}, 64'd1);
    step(1, rtype(5'd1, 5'd2, 5'd3, 6'h27), 0, 0);
    check("nor_alu", 64'(m_alu), 64'd6);

    // Reset with a valid instruction in ID/EX.
    check("pre_rst_valid", {63'd0, m_v}, 64'd1);
    async_reset();

    // Load-use on rs.
    step(1, itype(6'd35, 5'd1, 5'd9), 0, 0);
    step(1, rtype(5'd9, 5'd11, 5'd10, 6'h20), 0, 0);
    check("lu_stall", {63'd0, stall_seen}, 64'd1);
    check("lu_bubble", {63'd0, m_v}, 64'd0);
    check("lu_cnt", 64'(m_cnt), 64'd1);
    step(1, rtype(5'd9, 5'd11, 5'd10, 6'h20), 0, 0);
    check("lu_nostall", {63'd0, stall_seen}, 64'd0);
    check("lu_add", {59'd0, m_alu, m_v}, {59'd0, 4'd0, 1'b1});
    check("lu_dst", 64'(m_rd), 64'd10);

    // r0 never hazards; ADDI does not read rt.
    step(1, itype(6'd35, 5'd1, 5'd0), 0, 0);
    step(1, rtype(5'd0, 5'd0, 5'd4, 6'h20), 0, 0);
    check("r0_nostall", {62'd0, stall_seen, m_v}, 64'd1);
    step(1, itype(6'd35, 5'd1, 5'd9), 0, 0);
    step(1, itype(6'd8, 5'd3, 5'd9), 0, 0);
    check("addi_nostall", {62'd0, stall_seen, m_v}, 64'd1);

    // Hazard with flush: bubble, not counted.
    step(1, itype(6'd35, 5'd1, 5'd9), 0, 0);
    step(1, rtype(5'd9, 5'd2, 5'd3, 6'h20), 1, 0);
    check("flush_stall", {63'd0, stall_seen}, 64'd1);
    check("flush_bubble", {63'd0, m_v}, 64'd0);
    check("flush_cnt", 64'(m_cnt), 64'd1);

    // Hazard held for three cycles, then released.
    step(1, itype(6'd35, 5'd1, 5'd9), 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(1, rtype(5'd2, 5'd9, 5'd3, 6'h22), 0, 1);
      check("hold_stall", {63'd0, stall_seen}, 64'd1);
      check("hold_frozen", {62'd0, m_v, m_mr}, 64'd3);
      check("hold_cnt", 64'(m_cnt), 64'd1);
    end
    step(1, rtype(5'd2, 5'd9, 5'd3, 6'h22), 0, 0);
    check("hold_release_cnt", 64'(m_cnt), 64'd2);

    // Narrow counter saturation from a fresh reset.
    async_reset();
    for (int i = 0; i < 5; i++) begin
      step(1, itype(6'd35, 5'd4, 5'd9), 0, 0);
      step(1, rtype(5'd9, 5'd1, 5'd2, 6'h20), 0, 0);
      check("sat_cnt_c", 64'(c_cnt), 64'(exp6[i]));
    end

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      logic [31:0] ins;
      logic [5:0] op;
      logic [5:0] fn;
      int sel;
      sel = $urandom_range(0, 10);
      if (sel == 10) op = 6'($urandom);
      else op = op_pool[sel];
      fn = fn_pool[$urandom_range(0, 7)];
      ins = {op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
             5'($urandom_range(0, 7)), 5'($urandom), fn};
      step(($urandom_range(0, 7) != 0), ins, ($urandom_range(0, 9) == 0),
           ($urandom_range(0, 7) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
